// File: rtl/robot_step_scheduler_if.sv
// Step handshake between the scheduler (master) and the robot world (slave).
interface robot_step_scheduler_if;
    logic       step_req;
    logic       step_ack;
    logic [1:0] step_src;

    modport master (
        output step_req,
        output step_src,
        input  step_ack
    );

    modport slave (
        input  step_req,
        input  step_src,
        output step_ack
    );
endinterface

// File: rtl/robot_step_scheduler.sv
// Robot step scheduler: merges the debounced manual step key with a frame-based
// auto-step timer and hands at most one step per frame to the world, only while
// the display is in vertical blanking.
module robot_step_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned AUTO_FRAMES     = 30,
    parameter int unsigned FRAME_CNT_W     = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          step_key_n_i,
    input  logic                          auto_enable_i,
    input  logic                          vblank_i,
    input  logic                          vblank_start_i,
    robot_step_scheduler_if.master        step_if,
    output logic                          pending_o,
    output logic                          tear_flag_o,
    output logic [7:0]                    merged_cnt_o
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]        DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FRAME_CNT_W-1:0] AUTO_LAST = FRAME_CNT_W'(AUTO_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_COOLDOWN
    } state_e;

    logic                   sync1_q, sync2_q;
    logic                   deb_q;
    logic [DB_W-1:0]        db_cnt_q;
    logic                   press_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   auto_tick;

    state_e                 state_q, state_d;
    logic                   step_req_q, step_req_d;
    logic [1:0]             step_src_q, step_src_d;
    logic                   tear_q, tear_d;
    logic                   pend_man_q, pend_man_d;
    logic                   pend_auto_q, pend_auto_d;
    logic [7:0]             merged_q, merged_d;
    logic [1:0]             merge_inc;
    logic [8:0]             merged_sum;

    // Key synchronizer and debouncer; press_q pulses for one cycle on a debounced 1->0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            deb_q    <= 1'b1;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q <= step_key_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q != deb_q) begin
                if (db_cnt_q == DB_LAST) begin
                    deb_q    <= sync2_q;
                    db_cnt_q <= '0;
                    press_q  <= ~sync2_q;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    assign auto_tick = auto_enable_i && vblank_start_i && (frame_cnt_q == AUTO_LAST);

    // Auto-step frame counter, held at zero while auto stepping is off
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
        end else if (!auto_enable_i) begin
            frame_cnt_q <= '0;
        end else if (vblank_start_i) begin
            frame_cnt_q <= auto_tick ? '0 : frame_cnt_q + 1'b1;
        end
    end

    // Pending flags, merge counter and grant FSM next-state logic
    always_comb begin
        state_d     = state_q;
        step_req_d  = step_req_q;
        step_src_d  = step_src_q;
        tear_d      = tear_q;
        pend_man_d  = pend_man_q;
        pend_auto_d = pend_auto_q;

        // An event landing on an already-set flag (even one being granted now)
        // carries over to the next frame and counts as merged.
        merge_inc  = {1'b0, press_q & pend_man_q} + {1'b0, auto_tick & pend_auto_q};
        merged_sum = {1'b0, merged_q} + {7'd0, merge_inc};
        merged_d   = merged_sum[8] ? 8'hFF : merged_sum[7:0];

        unique case (state_q)
            S_IDLE: begin
                if ((pend_man_q || pend_auto_q) && vblank_i) begin
                    state_d     = S_STEP;
                    step_req_d  = 1'b1;
                    step_src_d  = {pend_auto_q, pend_man_q};
                    pend_man_d  = 1'b0;
                    pend_auto_d = 1'b0;
                end
            end
            S_STEP: begin
                if (!vblank_i) begin
                    tear_d = 1'b1;
                end
                if (step_if.step_ack) begin
                    state_d    = S_COOLDOWN;
                    step_req_d = 1'b0;
                end
            end
            S_COOLDOWN: begin
                if (!vblank_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (press_q) begin
            pend_man_d = 1'b1;
        end
        if (auto_tick) begin
            pend_auto_d = 1'b1;
        end
    end

    // Grant FSM and status registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            step_req_q  <= 1'b0;
            step_src_q  <= '0;
            tear_q      <= 1'b0;
            pend_man_q  <= 1'b0;
            pend_auto_q <= 1'b0;
            merged_q    <= '0;
        end else begin
            state_q     <= state_d;
            step_req_q  <= step_req_d;
            step_src_q  <= step_src_d;
            tear_q      <= tear_d;
            pend_man_q  <= pend_man_d;
            pend_auto_q <= pend_auto_d;
            merged_q    <= merged_d;
        end
    end

    assign step_if.step_req = step_req_q;
    assign step_if.step_src = step_src_q;
    assign pending_o        = pend_man_q | pend_auto_q;
    assign tear_flag_o      = tear_q;
    assign merged_cnt_o     = merged_q;

endmodule

// File: tb/tb_robot_step_scheduler.sv
// Self-checking bench for robot_step_scheduler: directed scenarios followed by
// randomized key/auto/ack traffic, all compared every cycle against a
// behavioural model of the scheduling rules.
`timescale 1ns/1ps
module tb_robot_step_scheduler;

    localparam int DB = 4;
    localparam int AF = 3;
    // Scaled-down raster keeps the run short; vblank covers rows VB..V-1.
    localparam int H  = 16;
    localparam int V  = 10;
    localparam int VB = 7;

    logic clock   = 1'b0;
    logic reset   = 1'b0;
    logic key_n   = 1'b1;
    logic auto_en = 1'b0;
    logic vblank  = 1'b0;
    logic vstart  = 1'b0;
    logic pending;
    logic tear;
    logic [7:0] merged;

    robot_step_scheduler_if step_if ();

    robot_step_scheduler #(
        .DEBOUNCE_CYCLES(DB),
        .AUTO_FRAMES    (AF),
        .FRAME_CNT_W    (6)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .step_key_n_i  (key_n),
        .auto_enable_i (auto_en),
        .vblank_i      (vblank),
        .vblank_start_i(vstart),
        .step_if       (step_if),
        .pending_o     (pending),
        .tear_flag_o   (tear),
        .merged_cnt_o  (merged)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Raster generator
    int px = 0;
    int py = 0;
    always @(negedge clock) begin
        if (px == H - 1) begin
            px = 0;
            py = (py == V - 1) ? 0 : py + 1;
        end else begin
            px = px + 1;
        end
        vblank = (py >= VB);
        vstart = (py == VB) && (px == 0);
    end

    // World side: acknowledges a request after a random delay
    logic ack_block   = 1'b1;
    logic spurious_en = 1'b0;
    int   ack_max     = 4;
    int   ack_cnt     = 0;
    int   ack_target  = 2;
    initial step_if.step_ack = 1'b0;
    always @(negedge clock) begin
        step_if.step_ack = 1'b0;
        if (step_if.step_req === 1'b1 && !ack_block) begin
            if (ack_cnt >= ack_target) begin
                step_if.step_ack = 1'b1;
                ack_cnt    = 0;
                ack_target = $urandom_range(0, ack_max);
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
            if (spurious_en && $urandom_range(0, 15) == 0) step_if.step_ack = 1'b1;
        end
    end

    // Step counter (rising edges of step_req)
    int   steps    = 0;
    logic prev_req = 1'b0;
    always @(negedge clock) begin
        if (step_if.step_req === 1'b1 && prev_req !== 1'b1) steps++;
        prev_req = step_if.step_req;
    end

    // Reference model. kq delays the raw key by two clocks; win holds the most
    // recent DB delayed samples, and the debounced level flips once all of them
    // disagree with it.
    bit   kq[$];
    bit   win[$];
    bit   m_deb = 1'b1, m_press = 1'b0;
    int   m_fc = 0;
    bit   m_pm = 1'b0, m_pa = 1'b0;
    bit   m_req = 1'b0, m_cool = 1'b0, m_tear = 1'b0;
    logic [1:0] m_src = 2'b00;
    int   m_merged = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            kq.delete();
            kq.push_back(1'b1);
            kq.push_back(1'b1);
            win.delete();
            m_deb = 1'b1; m_press = 1'b0; m_fc = 0;
            m_pm = 1'b0; m_pa = 1'b0;
            m_req = 1'b0; m_cool = 1'b0; m_tear = 1'b0;
            m_src = 2'b00; m_merged = 0;
        end else begin
            bit s, flip, np, tick, grant;
            bit nreq, ncool, npm, npa;
            int merges;
            s = kq.pop_front();
            kq.push_back(key_n);
            win.push_back(s);
            if (win.size() > DB) void'(win.pop_front());
            flip = (win.size() == DB);
            foreach (win[i]) if (win[i] == m_deb) flip = 1'b0;
            np = flip && m_deb;

            tick = auto_en && vstart && (m_fc == AF - 1);
            grant = !m_req && !m_cool && (m_pm || m_pa) && vblank;
            merges = int'(m_press && m_pm) + int'(tick && m_pa);
            npm = (m_pm && !grant) || m_press;
            npa = (m_pa && !grant) || tick;

            nreq = m_req;
            ncool = m_cool;
            if (grant) begin
                nreq = 1'b1;
                m_src = {m_pa, m_pm};
            end else if (m_req) begin
                if (!vblank) m_tear = 1'b1;
                if (step_if.step_ack) begin
                    nreq = 1'b0;
                    ncool = 1'b1;
                end
            end else if (m_cool && !vblank) begin
                ncool = 1'b0;
            end

            if (!auto_en)    m_fc = 0;
            else if (vstart) m_fc = tick ? 0 : m_fc + 1;

            m_merged = (m_merged + merges > 255) ? 255 : m_merged + merges;
            m_pm = npm; m_pa = npa;
            m_req = nreq; m_cool = ncool;
            if (flip) m_deb = ~m_deb;
            m_press = np;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        check_eq("step_req",   step_if.step_req, m_req);
        check_eq("step_src",   step_if.step_src, m_src);
        check_eq("pending",    pending,          m_pm | m_pa);
        check_eq("tear_flag",  tear,             m_tear);
        check_eq("merged_cnt", merged,           m_merged);
    end

    task automatic next_frame();
        int n = 0;
        do begin
            @(negedge clock); #1; n++;
        end while (!(px == 0 && py == 0) && n < 400);
        check_eq("frame_timeout", (n < 400) ? 1 : 0, 1);
    endtask

    task automatic wait_req(input logic lvl, input string tag);
        int n = 0;
        while (step_if.step_req !== lvl && n < 400) begin
            @(negedge clock); #1; n++;
        end
        check_eq(tag, (n < 400) ? 1 : 0, 1);
    endtask

    task automatic press(input int low);
        key_n = 1'b0;
        repeat (low) begin @(negedge clock); #1; end
        key_n = 1'b1;
        repeat (8) begin @(negedge clock); #1; end
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_req",    step_if.step_req, 0);
        check_eq("rst_src",    step_if.step_src, 0);
        check_eq("rst_pend",   pending,          0);
        check_eq("rst_tear",   tear,             0);
        check_eq("rst_merged", merged,           0);
        reset = 1'b1;
        ack_block = 1'b0;

        // Glitch shorter than the debounce window is rejected
        next_frame();
        base = steps;
        key_n = 1'b0;
        repeat (2) begin @(negedge clock); #1; end
        key_n = 1'b1;
        repeat (20) begin @(negedge clock); #1; end
        check_eq("glitch_pending", pending, 0);
        next_frame();
        check_eq("glitch_steps", steps - base, 0);

        // Manual press outside vblank waits for vblank, one step per frame
        next_frame();
        base = steps;
        press(10);
        check_eq("man_pending", pending, 1);
        check_eq("man_noreq",   step_if.step_req, 0);
        next_frame();
        check_eq("man_steps", steps - base, 1);
        check_eq("man_src",   step_if.step_src, 2'b01);

        // Second press before grant merges into the queued step
        next_frame();
        base = steps;
        press(10);
        press(10);
        check_eq("merge_cnt",  merged,  1);
        check_eq("merge_pend", pending, 1);
        next_frame();
        check_eq("merge_steps", steps - base, 1);

        // Auto stepping every AF frames, then disabled
        next_frame();
        auto_en = 1'b1;
        base = steps;
        repeat (8) next_frame();
        check_eq("auto_steps", steps - base, 2);
        check_eq("auto_src",   step_if.step_src, 2'b10);
        auto_en = 1'b0;
        base = steps;
        repeat (3) next_frame();
        check_eq("auto_off_steps", steps - base, 0);

        // Ack withheld past vblank end sets the sticky tear flag
        ack_block = 1'b1;
        press(10);
        wait_req(1'b1, "tear_req_up");
        while (vblank) begin @(negedge clock); #1; end
        repeat (3) begin @(negedge clock); #1; end
        check_eq("tear_set",  tear,             1);
        check_eq("tear_hold", step_if.step_req, 1);
        ack_block = 1'b0;
        wait_req(1'b0, "tear_req_down");
        repeat (3) begin @(negedge clock); #1; end
        check_eq("tear_sticky", tear, 1);

        // Reset mid-handshake, key held through reset
        next_frame();
        ack_block = 1'b1;
        key_n = 1'b0;
        wait_req(1'b1, "rst_req_up");
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_req",    step_if.step_req, 0);
        check_eq("async_src",    step_if.step_src, 0);
        check_eq("async_pend",   pending,          0);
        check_eq("async_tear",   tear,             0);
        check_eq("async_merged", merged,           0);
        repeat (3) @(negedge clock);
        ack_block = 1'b0;
        base = steps;
        reset = 1'b1;
        repeat (4) next_frame();
        key_n = 1'b1;
        repeat (2) next_frame();
        check_eq("held_key_steps", steps - base, 1);

        // Randomized traffic
        spurious_en = 1'b1;
        begin
            int ktimer = 0;
            for (int c = 0; c < 6400; c++) begin
                @(negedge clock); #1;
                if (ktimer == 0) begin
                    key_n  = ~key_n;
                    ktimer = key_n ? $urandom_range(1, 15) : $urandom_range(1, 12);
                end else begin
                    ktimer--;
                end
                if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
                if ($urandom_range(0, 399) == 0) ack_max = ($urandom_range(0, 3) == 0) ? 60 : 4;
            end
        end
        key_n = 1'b1;
        spurious_en = 1'b0;
        repeat (20) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
